// File: rtl/arbiter_rr_n.sv
// Round-robin N-input arbiter with per-winner burst locking and a one-stage registered output.
// Optional per-requester transfer counters are enabled with ARBITER_RR_N_STATS_EN.
module arbiter_rr_n #(
  parameter int DWIDTH = 16,
  parameter int N_IN   = 4,
  parameter int BURST  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_IN-1:0]           in_valid,
  input  logic [N_IN*DWIDTH-1:0]    in_data,
  output logic [N_IN-1:0]           in_ready,
  output logic                      out_valid,
  output logic [DWIDTH-1:0]         out_data,
  output logic [$clog2(N_IN)-1:0]   out_src,
  input  logic                      out_ready
`ifdef ARBITER_RR_N_STATS_EN
  ,
  input  logic [$clog2(N_IN)-1:0]   stat_sel,
  output logic [31:0]               stat_count
`endif
);

  localparam int SW = $clog2(N_IN);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       ptr_q, ptr_d;
  logic [7:0]          bcnt_q, bcnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DWIDTH-1:0]   out_data_q, out_data_d;
  logic [SW-1:0]       out_src_q, out_src_d;

  logic                load_en;
  logic                keep_lock;
  logic                have_win;
  logic                fire;
  logic [SW-1:0]       winner;
  logic [SW-1:0]       cand;
  int                  rr_idx;

  // Winner selection: hold the locked requester while it stays valid, otherwise
  // search ptr+1, ptr+2, ... (descending loop so the nearest candidate wins).
  always_comb begin
    load_en   = !out_valid_q || out_ready;
    keep_lock = (state_q == LOCKED) && in_valid[ptr_q];
    winner    = ptr_q;
    have_win  = keep_lock;
    rr_idx    = 0;
    cand      = '0;
    if (!keep_lock) begin
      for (int k = N_IN; k >= 1; k--) begin
        rr_idx = int'(ptr_q) + k;
        if (rr_idx >= N_IN) rr_idx = rr_idx - N_IN;
        cand = SW'(rr_idx);
        if (in_valid[cand]) begin
          winner   = cand;
          have_win = 1'b1;
        end
      end
    end
    fire     = have_win && load_en && !rst;
    in_ready = fire ? (N_IN'(1) << winner) : '0;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    bcnt_d      = bcnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (fire) begin
      if (keep_lock) begin
        bcnt_d = bcnt_q + 8'd1;
        if (bcnt_q + 8'd1 == 8'(BURST)) state_d = IDLE;
      end else begin
        ptr_d   = winner;
        bcnt_d  = 8'd1;
        state_d = (BURST > 1) ? LOCKED : IDLE;
      end
    end
    if (load_en) begin
      out_valid_d = fire;
      if (fire) begin
        out_data_d = in_data[int'(winner)*DWIDTH +: DWIDTH];
        out_src_d  = winner;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= SW'(N_IN - 1);
      bcnt_q      <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      bcnt_q      <= bcnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef ARBITER_RR_N_STATS_EN
  logic [N_IN*32-1:0] stat_flat;

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_stat
      logic [31:0] cnt_q, cnt_d;

      // Saturates at all-ones rather than wrapping.
      always_comb begin
        cnt_d = cnt_q;
        if (in_ready[gi] && in_valid[gi] && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
      end

      always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end

      assign stat_flat[gi*32 +: 32] = cnt_q;
    end
  endgenerate

  always_comb begin
    stat_count = '0;
    if (int'(stat_sel) < N_IN) stat_count = stat_flat[int'(stat_sel)*32 +: 32];
  end
`endif

endmodule
